// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding, ACK/NACK line levels, R/W bit values
// and input synchroniser depth, shared between the target and the bus master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK,
    REG,
    WDATA,
    RDATA,
    RACK,
    WAIT_STOP
  } state_t;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchronisers, optional majority glitch filter
// (I2C_GLITCH_FILTER_EN), edge registers and START/STOP detection.
module i2c_line_cond
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sclRise,
  output logic sclFall,
  output logic sdaLevel,
  output logic startDet,
  output logic stopDet
);

`ifdef I2C_GLITCH_FILTER_EN
  localparam bit FiltEnable = 1'b1;
`else
  localparam bit FiltEnable = 1'b0;
`endif
  // A one-tap window is a plain pass-through, so the unfiltered build is the Taps == 1 case.
  localparam int Taps = FiltEnable ? FILT_LEN : 1;

  logic [SYNC_STAGES-1:0] sclSync, sdaSync;
  logic sclS, sdaS;
  logic sclF, sdaF;
  logic sclPrev, sdaPrev;

  // Stage 1: metastability synchronisers; the bus idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclSync <= '1;
      sdaSync <= '1;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], scl};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], sda};
    end
  end

  assign sclS = sclSync[SYNC_STAGES-1];
  assign sdaS = sdaSync[SYNC_STAGES-1];

  if (Taps > 1) begin : gFilt
    logic [Taps-2:0] sclHist, sdaHist;

    function automatic logic majority(input logic [Taps-1:0] win);
      int ones;
      ones = 0;
      for (int i = 0; i < Taps; i++) ones += int'(win[i]);
      return (ones > Taps / 2);
    endfunction

    // Stage 2: sample history for the majority vote.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sclHist <= '1;
        sdaHist <= '1;
      end else begin
        sclHist <= {sclHist[Taps-3:0], sclS};
        sdaHist <= {sdaHist[Taps-3:0], sdaS};
      end
    end

    assign sclF = majority({sclHist, sclS});
    assign sdaF = majority({sdaHist, sdaS});
  end else begin : gDirect
    assign sclF = sclS;
    assign sdaF = sdaS;
  end

  // Stage 3: one-cycle-old copies for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclPrev <= sclF;
      sdaPrev <= sdaF;
    end
  end

  assign sclRise  = sclF & ~sclPrev;
  assign sclFall  = ~sclF & sclPrev;
  assign sdaLevel = sdaF;
  // SDA may only move with SCL held high across both samples to count as START/STOP.
  assign startDet = sclF & sclPrev & sdaPrev & ~sdaF;
  assign stopDet  = sclF & sclPrev & ~sdaPrev & sdaF;

endmodule

// File: rtl/i2c_slave_ram.sv
// I2C target exposing a 256x8 RAM: address match, register pointer, auto-incrementing
// burst writes and reads. Optional SCL/SDA glitch filter via I2C_GLITCH_FILTER_EN.
module i2c_slave_ram
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [6:0] slave_addr,
  input  logic [7:0] ram_dout,
  output logic [7:0] ram_add,
  output logic [7:0] ram_din,
  output logic       ram_w,
  output logic       busy,
  output logic       rd_active
);

  logic sclRise, sclFall, sdaLevel, startDet, stopDet;

  state_t     state, afterAck;
  logic [3:0] bitCnt;
  logic [7:0] shiftReg;
  logic [6:0] addrLatch;
  logic       sdaBit;
  logic       incPending;

  i2c_line_cond #(
    .FILT_LEN (FILT_LEN)
  ) uLineCond (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .sclRise  (sclRise),
    .sclFall  (sclFall),
    .sdaLevel (sdaLevel),
    .startDet (startDet),
    .stopDet  (stopDet)
  );

  assign sda = sdaBit ? 1'bz : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      afterAck   <= IDLE;
      bitCnt     <= '0;
      shiftReg   <= '0;
      addrLatch  <= '0;
      sdaBit     <= 1'b1;
      incPending <= 1'b0;
      ram_add    <= '0;
      ram_din    <= '0;
      ram_w      <= 1'b0;
      busy       <= 1'b0;
      rd_active  <= 1'b0;
    end else begin
      ram_w      <= 1'b0;
      incPending <= 1'b0;
      if (incPending) ram_add <= ram_add + 8'd1;

      if (startDet) begin
        state     <= ADDR;
        bitCnt    <= '0;
        addrLatch <= slave_addr;
        sdaBit    <= 1'b1;
        busy      <= 1'b0;
        rd_active <= 1'b0;
      end else if (stopDet) begin
        state     <= IDLE;
        bitCnt    <= '0;
        sdaBit    <= 1'b1;
        busy      <= 1'b0;
        rd_active <= 1'b0;
      end else begin
        case (state)
          ADDR, REG, WDATA: begin
            if (sclRise && bitCnt != 4'd8) begin
              shiftReg <= {shiftReg[6:0], sdaLevel};
              bitCnt   <= bitCnt + 4'd1;
            end else if (sclFall && bitCnt == 4'd8) begin
              bitCnt <= '0;
              if (state == ADDR) begin
                // General call (all-zero address) is never acknowledged.
                if (shiftReg[7:1] == addrLatch && addrLatch != 7'd0) begin
                  sdaBit    <= ACK_BIT;
                  busy      <= 1'b1;
                  state     <= ACK;
                  afterAck  <= (shiftReg[0] == RW_WRITE) ? REG : RDATA;
                  rd_active <= (shiftReg[0] == RW_READ);
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                if (state == REG) begin
                  ram_add <= shiftReg;
                end else begin
                  ram_din    <= shiftReg;
                  ram_w      <= 1'b1;
                  incPending <= 1'b1;
                end
                sdaBit   <= ACK_BIT;
                state    <= ACK;
                afterAck <= WDATA;
              end
            end
          end

          ACK: begin
            if (sclFall) begin
              bitCnt <= '0;
              if (afterAck == RDATA) begin
                shiftReg   <= ram_dout;
                sdaBit     <= ram_dout[7];
                incPending <= 1'b1;
                state      <= RDATA;
              end else begin
                sdaBit <= 1'b1;
                state  <= afterAck;
              end
            end
          end

          RDATA: begin
            if (sclRise) begin
              bitCnt <= bitCnt + 4'd1;
            end else if (sclFall) begin
              if (bitCnt == 4'd8) begin
                sdaBit <= 1'b1;
                state  <= RACK;
              end else begin
                shiftReg <= {shiftReg[6:0], 1'b0};
                sdaBit   <= shiftReg[6];
              end
            end
          end

          // Master ACK re-enters the ACK state so its closing SCL fall loads the next byte.
          RACK: begin
            if (sclRise) begin
              if (sdaLevel == NACK_BIT) begin
                state <= WAIT_STOP;
              end else begin
                state    <= ACK;
                afterAck <= RDATA;
              end
            end
          end

          IDLE, WAIT_STOP: begin
            sdaBit <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave_ram.md
Name: i2c_slave_ram

Overview:
- I2C target (slave) for the opposite end of our I2C master bus; lets a second Spartan board be read and written by the master controller.
- Detects START/STOP, matches a 7-bit address, takes a register-pointer byte, then writes bytes into a local 256x8 RAM or streams bytes out of it, auto-incrementing the pointer.
- Sits between the board pins (scl/sda) and the RAM controller's local write/read ports.

Parameters:
- FILT_LEN, 3, samples used by the optional glitch filter (odd, 3..7).

Ports:
- clk  input  1  system clock; must be at least 20x SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl  input  1  bus clock; this block never drives SCL.
- sda  inout  1  bus data, open-drain; driven 1'b0 or high-Z only.
- slave_addr  input  7  own address; sampled at each START.
- ram_dout  input  8  local RAM read data; valid 1 clk after ram_add changes.
- ram_add  output  8  RAM address; always equals the register pointer.
- ram_din  output  8  RAM write data.
- ram_w  output  1  RAM write strobe, 1-clk pulse.
- busy  output  1  high from address-match ACK to STOP or repeated START.
- rd_active  output  1  high while a read transfer is in progress.

Behaviour:
- Reset (reset=0, async) values: sda high-Z, ram_add=0, ram_din=0, ram_w=0, busy=0, rd_active=0, state IDLE, bit count 0.
- Input sync: 2-FF synchronisers on scl and sda, plus 1-FF edge registers. scl_rise, scl_fall and sda edges come from the synchronised copies.
- START: sda falls while scl=1. Valid in any state, including mid-byte, so repeated START works. Go to ADDR, clear bit count, latch slave_addr.
- STOP: sda rises while scl=1. Valid in any state. Go to IDLE, release sda, busy=0, rd_active=0. Pointer is retained.
- Bit timing: sample sda on scl_rise, MSB first. Change our sda only on scl_fall.
- ADDR: shift 8 bits.
  - Upper 7 bits == latched slave_addr: go to ACK. Bit0 is R/W.
  - Otherwise: go to WAIT_STOP with no ACK. Address 0x00 (general call) is never ACKed.
- ACK slot: on the scl_fall after bit 8, drive sda=0. Release it on the next scl_fall.
- After address ACK:
  - R/W=0: go to REG.
  - R/W=1: go to RDATA and set rd_active=1.
- REG: the first byte after a write address loads the pointer (ram_add) at its ACK-slot start. Then ACK and go to WDATA.
- WDATA, per byte:
  - At the scl_fall ending bit 8: ram_din=byte, ram_w=1 for exactly 1 clk, ram_add=pointer.
  - Pointer increments the following clk. Then ACK, then next WDATA.
- RDATA, per byte:
  - On the scl_fall that ends the ACK slot (or the address ACK), load the shift register from ram_dout and drive bit7. Pointer increments 1 clk later.
  - Drive the next bit on each scl_fall.
  - After bit 8, release sda and sample the master's ACK on scl_rise. ACK (0): next RDATA. NACK (1): WAIT_STOP.
- WAIT_STOP: sda released; wait for STOP or START.
- Pointer arithmetic: 8-bit, wraps 0xFF -> 0x00 for both reads and writes.
- Simultaneous events: START/STOP detection takes priority over any scl edge in the same clk.
- No clock stretching. Latency from scl_fall to sda change is 3-4 clk (sync plus register).

Optional Feature:
- I2C_GLITCH_FILTER_EN defined: after sync, scl and sda pass through a FILT_LEN-sample majority filter. This rejects spikes shorter than FILT_LEN/2 clk and adds (FILT_LEN-1)/2 clk latency.
- Undefined: the synchronised signals are used directly and FILT_LEN is ignored.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding constants (IDLE, ADDR, ACK, REG, WDATA, RDATA, RACK, WAIT_STOP);
  - the ACK/NACK bit constants;
  - the R/W bit constants, shared with the master.
- One sub-module, i2c_line_cond: synchroniser, optional filter, edge and START/STOP detection. Instantiated once, covering both lines.

Test Plan:
- Write: slave_addr=7'h42; master sends START, 0x84, 0x10, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; ram_w pulses twice (0x10<=0xA5, 0x11<=0x5A); ram_add=0x12 after STOP.
- Read: RAM[0x20]=0x11, RAM[0x21]=0x22; master sends START, 0x84, 0x20, repeated START, 0x85, reads 2 bytes (ACK then NACK), STOP -> sda carries 0x11 then 0x22; rd_active drops at STOP.
- Mismatch: address 0x86 (7'h43) -> no ACK (sda high-Z in slot 9), no ram_w, busy stays 0 until STOP.
- Wrap: pointer 0xFF, write 0x01, 0x02 -> RAM[0xFF]=0x01, RAM[0x00]=0x02.
- Abort: START mid-byte during WDATA after 4 bits -> no ram_w, state ADDR. Then assert reset=0 mid-read -> sda high-Z immediately, all outputs at reset values.
- With I2C_GLITCH_FILTER_EN: 1-clk low spike on scl during WDATA -> no extra bit shifted, written byte correct.
